mips_debug_controller: RTL

Sequential successor to the combinational MicroBlaze-to-MIPS frame pass-through. It accepts command frames from MicroBlaze GPIO with a valid strobe and decodes {code, type, data}. It drives MIPS reset, run and step control, loads the instruction memory, and issues debug read requests. It returns exactly one reply frame per accepted command. Sits between the MicroBlaze GPIO block and the MIPS top level.

---
 rtl/mips_debug_pkg.sv | 83 ++++++++
 rtl/mips_debug_controller_imem_loader.sv | 67 ++++++
 rtl/mips_debug_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_debug_pkg.sv
// ---------------------------------------------------------------------------
// mips_debug_pkg
// Shared definitions for the MicroBlaze-to-MIPS debug controller: frame
// field widths, command codes, debug request types, error reply fields,
// run-mode and FSM encodings, plus small helpers that build reply frames.
// Frame layout (MSB..LSB): {code[5:0], type[9:0], data[15:0]}.
// ---------------------------------------------------------------------------
package mips_debug_pkg;

    localparam int NB_CONTROL_FRAME = 32;
    localparam int NB_INSTR_CODE    = 6;
    localparam int NB_INSTR_ADDRESS = 10;
    localparam int NB_INSTR_DATA    = 16;
    localparam int NB_MIPS_WORD     = 2 * NB_INSTR_DATA;
    localparam int NB_IMEM_ADDR     = 10;
    localparam int REQ_TIMEOUT      = 255;
    localparam int NB_REQ_CNT       = $clog2(REQ_TIMEOUT + 1);

    // Command codes
    localparam logic [NB_INSTR_CODE-1:0] CMD_START          = 6'b000001;
    localparam logic [NB_INSTR_CODE-1:0] CMD_RESET          = 6'b000010;
    localparam logic [NB_INSTR_CODE-1:0] CMD_REQ_DATA       = 6'b000011;
    localparam logic [NB_INSTR_CODE-1:0] CMD_LOAD_INSTR_LSB = 6'b000100;
    localparam logic [NB_INSTR_CODE-1:0] CMD_LOAD_INSTR_MSB = 6'b000101;
    localparam logic [NB_INSTR_CODE-1:0] CMD_MODE_GET       = 6'b001000;
    localparam logic [NB_INSTR_CODE-1:0] CMD_MODE_SET       = 6'b001001;
    localparam logic [NB_INSTR_CODE-1:0] CMD_STEP           = 6'b100000;

    // Debug read request types (carried in the type field of REQ_DATA)
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_MEM_DATA          = 10'd1;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_MEM_INSTR         = 10'd2;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_REG               = 10'd3;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_REG_PC            = 10'd5;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_IF_ID_DATA  = 10'd6;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_ID_EX_DATA  = 10'd7;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_ID_EX_CTRL  = 10'd8;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_EX_MEM_DATA = 10'd9;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_EX_MEM_CTRL = 10'd10;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_MEM_WB_DATA = 10'd11;
    localparam logic [NB_INSTR_ADDRESS-1:0] REQ_LATCH_MEM_WB_CTRL = 10'd12;

    // Error reply fields
    localparam logic [NB_INSTR_CODE-1:0] ERR_CODE         = '1;
    localparam logic [NB_INSTR_DATA-1:0] ERR_DATA         = '1;
    localparam logic [NB_INSTR_DATA-1:0] ERR_DATA_TIMEOUT = 16'hDEAD;

    typedef enum logic {
        MODE_CONTINUOUS = 1'b0,
        MODE_STEP       = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_REQ_WAIT = 2'd2,
        ST_REPLY    = 2'd3
    } state_t;

    function automatic logic is_valid_req_type(input logic [NB_INSTR_ADDRESS-1:0] t);
        case (t)
            REQ_MEM_DATA, REQ_MEM_INSTR, REQ_REG, REQ_REG_PC,
            REQ_LATCH_IF_ID_DATA, REQ_LATCH_ID_EX_DATA, REQ_LATCH_ID_EX_CTRL,
            REQ_LATCH_EX_MEM_DATA, REQ_LATCH_EX_MEM_CTRL,
            REQ_LATCH_MEM_WB_DATA, REQ_LATCH_MEM_WB_CTRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [NB_CONTROL_FRAME-1:0] ack_frame(
        input logic [NB_INSTR_CODE-1:0]    c,
        input logic [NB_INSTR_ADDRESS-1:0] t
    );
        return {c, t, {NB_INSTR_DATA{1'b0}}};
    endfunction

    function automatic logic [NB_CONTROL_FRAME-1:0] err_frame(
        input logic [NB_INSTR_ADDRESS-1:0] t,
        input logic [NB_INSTR_DATA-1:0]    d
    );
        return {ERR_CODE, t, d};
    endfunction

endpackage

// File: rtl/mips_debug_controller_imem_loader.sv
// ---------------------------------------------------------------------------
// mips_imem_loader
// Assembles 32-bit instruction words from two 16-bit halves and writes them
// to consecutive instruction-memory addresses.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_clear          : RESET command (clears address and held half)
//   i_lsb_load       : latch i_data as the low half, set the LSB flag
//   i_msb_write      : write {i_data, held LSB}; caller has already checked
//                      that the LSB flag is set and MIPS is not running
//   o_lsb_flag       : a low half is held and waiting for its high half
//   o_wr_en/addr/data: one-cycle instruction memory write
// The address counter wraps naturally at 2^NB_IMEM_ADDR.
// ---------------------------------------------------------------------------
module mips_imem_loader
    import mips_debug_pkg::*;
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_lsb_load,
    input  logic                     i_msb_write,
    input  logic [NB_INSTR_DATA-1:0] i_data,
    output logic                     o_lsb_flag,
    output logic                     o_wr_en,
    output logic [NB_IMEM_ADDR-1:0]  o_wr_addr,
    output logic [NB_MIPS_WORD-1:0]  o_wr_data
);

    logic [NB_INSTR_DATA-1:0] r_lsb_hold;
    logic                     r_lsb_flag;
    logic [NB_IMEM_ADDR-1:0]  r_load_addr;
    logic                     r_wr_en;
    logic [NB_IMEM_ADDR-1:0]  r_wr_addr;
    logic [NB_MIPS_WORD-1:0]  r_wr_data;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_lsb_hold  <= '0;
            r_lsb_flag  <= 1'b0;
            r_load_addr <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_clear) begin
                r_lsb_flag  <= 1'b0;
                r_load_addr <= '0;
            end else if (i_lsb_load) begin
                r_lsb_hold <= i_data;
                r_lsb_flag <= 1'b1;
            end else if (i_msb_write) begin
                r_wr_en     <= 1'b1;
                r_wr_addr   <= r_load_addr;
                r_wr_data   <= {i_data, r_lsb_hold};
                r_load_addr <= r_load_addr + 1'b1;
                r_lsb_flag  <= 1'b0;
            end
        end
    end

    assign o_lsb_flag = r_lsb_flag;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;

endmodule

// File: rtl/mips_debug_controller.sv
// ---------------------------------------------------------------------------
// mips_debug_controller
// Accepts command frames from the MicroBlaze GPIO, drives MIPS reset /
// run / step control, loads instruction memory, issues debug reads and
// returns exactly one reply frame per accepted command.
//   i_clock, i_reset        : clock, synchronous active-high reset
//   i_frame_from_blaze/valid: command frame in (ignored while o_busy)
//   o_busy                  : accept .. reply cycle inclusive
//   o_frame_to_blaze/_valid : reply frame (held) and one-cycle strobe
//   o_mips_reset/enable     : MIPS reset and clock-enable
//   o_imem_wr_*             : instruction memory write port
//   o_req_*, i_req_data*    : debug read request / response
// Optional build macro: MIPS_DEBUG_REQ_TIMEOUT_EN -- abandons a debug read
// after REQ_TIMEOUT cycles and replies ERR with data 16'hDEAD.
// Timing: accept edge -> EXEC; side effects registered on the next edge;
// reply strobe registered one edge after that.
// ---------------------------------------------------------------------------
module mips_debug_controller
    import mips_debug_pkg::*;
(
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
    input  logic                        i_frame_valid,
    output logic                        o_busy,
    output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
    output logic                        o_frame_to_blaze_valid,
    output logic                        o_mips_reset,
    output logic                        o_mips_enable,
    output logic                        o_imem_wr_en,
    output logic [NB_IMEM_ADDR-1:0]     o_imem_wr_addr,
    output logic [NB_MIPS_WORD-1:0]     o_imem_wr_data,
    output logic                        o_req_valid,
    output logic [NB_INSTR_ADDRESS-1:0] o_req_type,
    output logic [NB_INSTR_DATA-1:0]    o_req_index,
    input  logic [NB_MIPS_WORD-1:0]     i_req_data,
    input  logic                        i_req_data_valid
);

    state_t                      r_state;
    mode_t                       r_mode;
    logic                        r_running;
    logic                        r_busy;
    logic [NB_CONTROL_FRAME-1:0] r_frame;
    logic [NB_CONTROL_FRAME-1:0] r_reply;
`ifdef MIPS_DEBUG_REQ_TIMEOUT_EN
    logic [NB_REQ_CNT-1:0]       r_wait_cnt;
`endif

    logic [NB_INSTR_CODE-1:0]    w_code;
    logic [NB_INSTR_ADDRESS-1:0] w_type;
    logic [NB_INSTR_DATA-1:0]    w_data;
    logic                        w_exec;
    logic                        w_lsb_flag;
    logic                        w_msb_ok;
    logic                        w_lsb_load;
    logic                        w_msb_write;
    logic                        w_clear;

    assign w_code = r_frame[NB_CONTROL_FRAME-1 -: NB_INSTR_CODE];
    assign w_type = r_frame[NB_INSTR_DATA +: NB_INSTR_ADDRESS];
    assign w_data = r_frame[NB_INSTR_DATA-1:0];

    // Loader strobes are decoded from the latched frame during EXEC so the
    // write lands on the same edge as every other side effect.
    assign w_exec      = (r_state == ST_EXEC);
    assign w_msb_ok    = w_lsb_flag && !r_running;
    assign w_lsb_load  = w_exec && (w_code == CMD_LOAD_INSTR_LSB);
    assign w_msb_write = w_exec && (w_code == CMD_LOAD_INSTR_MSB) && w_msb_ok;
    assign w_clear     = w_exec && (w_code == CMD_RESET);

    mips_imem_loader u_loader (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (w_clear),
        .i_lsb_load  (w_lsb_load),
        .i_msb_write (w_msb_write),
        .i_data      (w_data),
        .o_lsb_flag  (w_lsb_flag),
        .o_wr_en     (o_imem_wr_en),
        .o_wr_addr   (o_imem_wr_addr),
        .o_wr_data   (o_imem_wr_data)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state                <= ST_IDLE;
            r_mode                 <= MODE_CONTINUOUS;
            r_running              <= 1'b0;
            r_busy                 <= 1'b0;
            r_frame                <= '0;
            r_reply                <= '0;
            o_frame_to_blaze       <= '0;
            o_frame_to_blaze_valid <= 1'b0;
            o_mips_reset           <= 1'b1;
            o_mips_enable          <= 1'b0;
            o_req_valid            <= 1'b0;
            o_req_type             <= '0;
            o_req_index            <= '0;
`ifdef MIPS_DEBUG_REQ_TIMEOUT_EN
            r_wait_cnt             <= '0;
`endif
        end else begin
            o_frame_to_blaze_valid <= 1'b0;
            // Busy stays high through the reply-strobe cycle itself.
            if (o_frame_to_blaze_valid) begin
                r_busy <= 1'b0;
            end
            // In step mode the enable is only ever a single-cycle pulse.
            if (r_mode == MODE_STEP) begin
                o_mips_enable <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_frame_valid && !r_busy) begin
                        r_frame <= i_frame_from_blaze;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_state <= ST_REPLY;
                    r_reply <= ack_frame(w_code, w_type);
                    case (w_code)
                        CMD_START: begin
                            o_mips_reset <= 1'b0;
                            r_running    <= 1'b1;
                            if (r_mode == MODE_CONTINUOUS) begin
                                o_mips_enable <= 1'b1;
                            end
                        end
                        CMD_RESET: begin
                            o_mips_reset  <= 1'b1;
                            o_mips_enable <= 1'b0;
                            r_running     <= 1'b0;
                        end
                        CMD_LOAD_INSTR_LSB: begin
                            // Held by the loader; plain ACK here.
                        end
                        CMD_LOAD_INSTR_MSB: begin
                            if (!w_msb_ok) begin
                                r_reply <= err_frame(w_type, ERR_DATA);
                            end
                        end
                        CMD_MODE_SET: begin
                            if (r_running) begin
                                r_reply <= err_frame(w_type, ERR_DATA);
                            end else begin
                                r_mode <= mode_t'(w_data[0]);
                            end
                        end
                        CMD_MODE_GET: begin
                            r_reply <= {w_code, w_type, {(NB_INSTR_DATA-1){1'b0}}, r_mode};
                        end
                        CMD_STEP: begin
                            if (r_running && (r_mode == MODE_STEP)) begin
                                o_mips_enable <= 1'b1;
                            end else begin
                                r_reply <= err_frame(w_type, ERR_DATA);
                            end
                        end
                        CMD_REQ_DATA: begin
                            if (is_valid_req_type(w_type)) begin
                                o_req_valid <= 1'b1;
                                o_req_type  <= w_type;
                                o_req_index <= w_data;
                                r_state     <= ST_REQ_WAIT;
`ifdef MIPS_DEBUG_REQ_TIMEOUT_EN
                                r_wait_cnt  <= '0;
`endif
                            end else begin
                                r_reply <= err_frame(w_type, ERR_DATA);
                            end
                        end
                        default: begin
                            r_reply <= err_frame(w_type, ERR_DATA);
                        end
                    endcase
                end

                ST_REQ_WAIT: begin
                    if (i_req_data_valid) begin
                        o_req_valid <= 1'b0;
                        r_reply     <= i_req_data;
                        r_state     <= ST_REPLY;
                    end
`ifdef MIPS_DEBUG_REQ_TIMEOUT_EN
                    else if (r_wait_cnt == NB_REQ_CNT'(REQ_TIMEOUT - 1)) begin
                        o_req_valid <= 1'b0;
                        r_reply     <= err_frame(w_type, ERR_DATA_TIMEOUT);
                        r_state     <= ST_REPLY;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                ST_REPLY: begin
                    o_frame_to_blaze       <= r_reply;
                    o_frame_to_blaze_valid <= 1'b1;
                    r_state                <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;

endmodule
